serv_wb_arbiter_reg: RTL and testbench

Registered Wishbone arbiter that sits directly downstream of the SERV CPU top. It merges the CPU's instruction bus and data bus onto one classic-cycle Wishbone master port toward memory and peripherals. The arbiter breaks the combinational path from the CPU bus outputs to the memory port and registers the read data back. It also enforces a bus watchdog, so a missing slave terminates the access with an error instead of hanging the core.

---
 rtl/serv_wb_pkg.sv | 14 +
 rtl/serv_wb_watchdog.sv | 25 ++
 rtl/serv_wb_arbiter_reg.sv | 144 ++++++++++++++
 tb/tb_serv_wb_arbiter_reg.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_wb_pkg.sv
// Shared definitions for the SERV Wishbone arbiter: FSM state encoding and the
// default read data returned on a failed access.
package serv_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIbus = 2'd1,
    StDbus = 2'd2,
    StResp = 2'd3
  } wb_state_e;

  localparam logic [31:0] ErrRdtDefault = 32'h0000_0000;

endpackage

// File: rtl/serv_wb_watchdog.sv
// Bus watchdog: counts cycles while an access is outstanding and flags expiry
// once the counter reaches all-ones.
module serv_wb_watchdog #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign o_expired = &cnt_q;

endmodule

// File: rtl/serv_wb_arbiter_reg.sv
// Registered Wishbone arbiter merging the SERV instruction and data buses onto
// one classic-cycle master port, with a watchdog that turns missing slaves into errors.
module serv_wb_arbiter_reg
  import serv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter logic [31:0] ERR_RDT   = ErrRdtDefault
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_bus_err,
  output logic [31:0] o_err_adr,
  output logic [7:0]  o_err_cnt
);

  wb_state_e   state_q, state_d;
  logic        gnt_dbus_q;
  logic        fail_q;
  logic [31:0] ibus_rdt_q, dbus_rdt_q;
  logic [31:0] wb_adr_q, wb_dat_q;
  logic [3:0]  wb_sel_q;
  logic        wb_we_q;
  logic [31:0] err_adr_q;
  logic [7:0]  err_cnt_q;
  logic        busy, expired, done, fail;

  assign busy = (state_q == StIbus) || (state_q == StDbus);

  serv_wb_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (state_q == StIdle),
    .i_en     (busy),
    .o_expired(expired)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    fail    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_dbus_cyc) begin
          state_d = StDbus;
        end else if (i_ibus_cyc) begin
          state_d = StIbus;
        end
      end
      StIbus, StDbus: begin
        if (i_wb_ack || i_wb_err || expired) begin
          done    = 1'b1;
          // Error beats ack; a real ack beats a coincident watchdog expiry.
          fail    = i_wb_err || (expired && !i_wb_ack);
          state_d = StResp;
        end
      end
      // Requests are deliberately not sampled here: the master's cyc is still high.
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      gnt_dbus_q <= 1'b0;
      fail_q     <= 1'b0;
      ibus_rdt_q <= '0;
      dbus_rdt_q <= '0;
      wb_adr_q   <= '0;
      wb_dat_q   <= '0;
      wb_sel_q   <= '0;
      wb_we_q    <= 1'b0;
      err_adr_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d == StDbus) begin
        gnt_dbus_q <= 1'b1;
        wb_adr_q   <= i_dbus_adr;
        wb_dat_q   <= i_dbus_dat;
        wb_sel_q   <= i_dbus_sel;
        wb_we_q    <= i_dbus_we;
      end else if (state_q == StIdle && state_d == StIbus) begin
        gnt_dbus_q <= 1'b0;
        wb_adr_q   <= i_ibus_adr;
        wb_dat_q   <= '0;
        wb_sel_q   <= 4'hF;
        wb_we_q    <= 1'b0;
      end
      if (done) begin
        fail_q <= fail;
        if (gnt_dbus_q) begin
          dbus_rdt_q <= fail ? ERR_RDT : i_wb_rdt;
        end else begin
          ibus_rdt_q <= fail ? ERR_RDT : i_wb_rdt;
        end
        if (fail) begin
          err_adr_q <= wb_adr_q;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign o_wb_cyc   = busy;
  assign o_wb_stb   = busy;
  assign o_wb_adr   = wb_adr_q;
  assign o_wb_dat   = wb_dat_q;
  assign o_wb_sel   = wb_sel_q;
  assign o_wb_we    = wb_we_q;
  assign o_ibus_ack = (state_q == StResp) && !gnt_dbus_q;
  assign o_dbus_ack = (state_q == StResp) && gnt_dbus_q;
  assign o_ibus_rdt = ibus_rdt_q;
  assign o_dbus_rdt = dbus_rdt_q;
  assign o_bus_err  = (state_q == StResp) && fail_q;
  assign o_err_adr  = err_adr_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_serv_wb_arbiter_reg.sv
// Self-checking bench for serv_wb_arbiter_reg: directed transactions with a
// scoreboard of expected master responses and a small configurable slave.
module tb_serv_wb_arbiter_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr, dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack, wb_err;
  logic        bus_err;
  logic [31:0] err_adr;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        dbus;
    logic [31:0] rdt;
    logic        err;
    logic [31:0] adr;
  } exp_t;
  exp_t sb[$];

  int          exp_err_cnt = 0;
  // Slave behaviour: 0 ack after slv_wait, 1 silent, 2 ack+err, 3 err only.
  int          slv_mode = 0;
  int          slv_wait = 0;
  int          slv_cnt  = 0;
  logic [31:0] slv_rdt  = '0;

  serv_wb_arbiter_reg #(
    .TIMEOUT_W(4)
  ) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_ibus_adr(ibus_adr),
    .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(ibus_rdt),
    .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr),
    .i_dbus_dat(dbus_dat),
    .i_dbus_sel(dbus_sel),
    .i_dbus_we (dbus_we),
    .i_dbus_cyc(dbus_cyc),
    .o_dbus_rdt(dbus_rdt),
    .o_dbus_ack(dbus_ack),
    .o_wb_adr  (wb_adr),
    .o_wb_dat  (wb_dat),
    .o_wb_sel  (wb_sel),
    .o_wb_we   (wb_we),
    .o_wb_cyc  (wb_cyc),
    .o_wb_stb  (wb_stb),
    .i_wb_rdt  (wb_rdt),
    .i_wb_ack  (wb_ack),
    .i_wb_err  (wb_err),
    .o_bus_err (bus_err),
    .o_err_adr (err_adr),
    .o_err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: responses are set up mid-cycle so the DUT samples them at the next edge.
  always @(negedge clk) begin
    if (wb_cyc) begin
      wb_ack = (slv_mode == 0 && slv_cnt == slv_wait) || slv_mode == 2;
      wb_err = (slv_mode >= 2);
      wb_rdt = wb_ack ? slv_rdt : $urandom;
      slv_cnt++;
    end else begin
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
      wb_rdt  = $urandom;
      slv_cnt = 0;
    end
  end

  // Scoreboard: every master ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ibus_ack || dbus_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_dbus", dbus_ack, e.dbus);
        chk("ack_ibus", ibus_ack, !e.dbus);
        chk("rdt", e.dbus ? dbus_rdt : ibus_rdt, e.rdt);
        chk("bus_err", bus_err, e.err);
        if (e.err) begin
          if (exp_err_cnt < 255) exp_err_cnt++;
          chk("err_adr", err_adr, e.adr);
        end
        chk("err_cnt", err_cnt, exp_err_cnt);
      end
    end else if (bus_err) begin
      chk("stray_bus_err", bus_err, 1'b0);
    end
  end

  // Drive one or both masters; each drops cyc one cycle after its ack, i.e. the
  // cyc is still high at the edge leaving the response cycle. Cycle 0 = request raised.
  task automatic serve(input logic ri, input logic rd, input logic [31:0] iadr,
                       input logic [31:0] dadr, input logic [31:0] ddat,
                       input logic [3:0] dsel, input logic dwe, input logic [31:0] exp_rdt,
                       input logic exp_err, output int d_ack, output int i_ack,
                       output int i_first, output int ncyc);
    int   n;
    logic d_done, i_done;
    d_ack = -1; i_ack = -1; i_first = -1; ncyc = 0;
    @(negedge clk);
    ibus_adr = iadr; dbus_adr = dadr; dbus_dat = ddat; dbus_sel = dsel; dbus_we = dwe;
    ibus_cyc = ri;
    dbus_cyc = rd;
    if (rd) sb.push_back('{1'b1, exp_rdt, exp_err, dadr});
    if (ri) sb.push_back('{1'b0, exp_rdt, exp_err, iadr});
    d_done = !rd;
    i_done = !ri;
    n = 0;
    while (!(d_done && i_done) && n < 100) begin
      @(negedge clk);
      n++;
      if (d_ack >= 0 && !d_done && n == d_ack + 1) begin dbus_cyc = 1'b0; d_done = 1'b1; end
      if (i_ack >= 0 && !i_done && n == i_ack + 1) begin ibus_cyc = 1'b0; i_done = 1'b1; end
      if (wb_cyc) begin
        ncyc++;
        chk("stb", wb_stb, 1'b1);
        if (rd && d_ack < 0) begin
          chk("d_adr", wb_adr, dadr);
          chk("d_dat", wb_dat, ddat);
          chk("d_sel", wb_sel, dsel);
          chk("d_we", wb_we, dwe);
        end else begin
          if (i_first < 0) i_first = n;
          chk("i_adr", wb_adr, iadr);
          chk("i_dat", wb_dat, 32'd0);
          chk("i_sel", wb_sel, 4'hF);
          chk("i_we", wb_we, 1'b0);
        end
      end
      if (dbus_ack) d_ack = n;
      if (ibus_ack) i_ack = n;
    end
    chk("txn_bound", {30'd0, d_done, i_done}, 32'd3);
    @(negedge clk);
    chk("no_regrant", wb_cyc, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {wb_cyc, wb_stb, wb_we, ibus_ack, dbus_ack, bus_err}, 32'd0);
    chk({tag, "_adr"}, wb_adr, 32'd0);
    chk({tag, "_dat"}, wb_dat, 32'd0);
    chk({tag, "_sel"}, wb_sel, 32'd0);
    chk({tag, "_irdt"}, ibus_rdt, 32'd0);
    chk({tag, "_drdt"}, dbus_rdt, 32'd0);
    chk({tag, "_eadr"}, err_adr, 32'd0);
    chk({tag, "_ecnt"}, err_cnt, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int da, ia, ifst, nc;
    rst_n = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_rdt = '0; wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Zero-wait ibus fetch; dbus inputs carry junk that must not leak through.
    slv_mode = 0; slv_wait = 0; slv_rdt = 32'h0000_0013;
    serve(1'b1, 1'b0, 32'h100, 32'h9999, 32'h1234_5678, 4'b0101, 1'b1,
          32'h13, 1'b0, da, ia, ifst, nc);
    chk("t1_i_ack_cyc", ia, 2);
    chk("t1_no_dack", da, -1);
    chk("t1_ncyc", nc, 1);
    chk("t1_ifirst", ifst, 1);

    // Simultaneous requests: dbus write first, ibus granted the cycle after RESP.
    slv_rdt = 32'h0000_0013;
    serve(1'b1, 1'b1, 32'h104, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1,
          32'h13, 1'b0, da, ia, ifst, nc);
    chk("t2_d_ack_cyc", da, 2);
    chk("t2_i_first", ifst, 4);
    chk("t2_i_ack_cyc", ia, 5);
    chk("t2_ncyc", nc, 2);

    // Five wait states.
    slv_wait = 5; slv_rdt = 32'hCAFE_F00D;
    serve(1'b0, 1'b1, 32'h0, 32'h1000, 32'h5555_AAAA, 4'b1100, 1'b0,
          32'hCAFE_F00D, 1'b0, da, ia, ifst, nc);
    chk("t3_ncyc", nc, 6);
    chk("t3_d_ack_cyc", da, 7);
    chk("t3_drdt_hold", dbus_rdt, 32'hCAFE_F00D);

    // Silent slave: watchdog (TIMEOUT_W=4) ends the access 16 cycles after grant.
    slv_mode = 1;
    serve(1'b0, 1'b1, 32'h0, 32'h5000, 32'h0, 4'hF, 1'b0,
          32'h0, 1'b1, da, ia, ifst, nc);
    chk("t4_ncyc", nc, 16);
    chk("t4_d_ack_cyc", da, 17);
    chk("t4_err_adr", err_adr, 32'h5000);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_irdt_hold", ibus_rdt, 32'h13);

    // Ack and error together: error wins.
    slv_mode = 2; slv_rdt = 32'h7777_7777;
    serve(1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 4'hF, 1'b0,
          32'h0, 1'b1, da, ia, ifst, nc);
    chk("t5_d_ack_cyc", da, 2);
    chk("t5_err_adr", err_adr, 32'h40);
    chk("t5_err_cnt", err_cnt, 2);

    // Reset in the middle of a dbus wait.
    slv_mode = 1;
    @(negedge clk);
    dbus_adr = 32'h3000; dbus_cyc = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_pre_cyc", wb_cyc, 1'b1);
    rst_n = 1'b0;
    exp_err_cnt = 0;
    @(negedge clk);
    chk_all_zero("t6_rst");
    dbus_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_post_cyc", wb_cyc, 1'b0);

    // Normal service resumes after reset.
    slv_mode = 0; slv_wait = 1; slv_rdt = 32'hA5A5_0001;
    serve(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 4'h0, 1'b0,
          32'hA5A5_0001, 1'b0, da, ia, ifst, nc);
    chk("t7_i_ack_cyc", ia, 3);
    chk("t7_ncyc", nc, 2);

    // 256 forced errors saturate the error counter.
    slv_mode = 3;
    for (int k = 0; k < 256; k++) begin
      serve(1'b0, 1'b1, 32'h0, 32'h8000 + 32'(k) * 4, 32'h0, 4'hF, 1'b1,
            32'h0, 1'b1, da, ia, ifst, nc);
    end
    chk("t8_err_cnt_sat", err_cnt, 8'd255);
    chk("t8_err_adr", err_adr, 32'h8000 + 32'd255 * 4);
    chk("t8_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
